or4_vector_checker: RTL and testbench
=====================================

// Module: or4_vector_checker
// PURPOSE
//  Synthesizable response checker for the 4-input OR gate. It drives all 16 input
//  vectors into the OR gate under test (CUT), waits a settle time, samples the CUT
//  result and compares it with the golden OR of the same vector. It counts mismatches
//  and reports pass/fail, replacing the manual display-and-inspect flow with hardware checking.
// PARAMETERS
//  SETTLE_CYCLES  2  cycles each vector is held before res is sampled (legal range >= 1)
//  ERR_W          8  width of the mismatch counter
// PORTS
//  clk              in   1      single clock, rising edge
//  rst_n            in   1      synchronous, active-low reset
//  start            in   1      begin a run; sampled only in IDLE
//  a, b, c, d       out  1      CUT inputs; {a,b,c,d} = current vector (a is the MSB)
//  res              in   1      CUT output
//  busy             out  1      high from the cycle after start until DONE is left
//  done             out  1      one-cycle pulse at the end of a run
//  pass             out  1      1 when err_count==0; valid from done until the next start
//  err_count        out  ERR_W  mismatch count; saturates at 2**ERR_W-1
//  first_fail_vec   out  4      vector of the first mismatch in the run
//  first_fail_valid out  1      first_fail_vec holds a captured mismatch
// BEHAVIOUR
//  Reset (rst_n==0 at a clk edge): state=IDLE; vec=0; wait_cnt=0; outputs a..d=0,
//   busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0.
//   Reset asserted mid-run aborts the run immediately. No partial result is kept.
//  FSM states: IDLE, SETTLE, CHECK, DONE.
//   IDLE: on start=1, clear vec, wait_cnt, err_count, first_fail_*, and pass, then go to SETTLE.
//    With start=0, remain in IDLE.
//   SETTLE: {a,b,c,d} are registered from vec and stay stable. wait_cnt increments.
//    When wait_cnt==SETTLE_CYCLES-1, clear wait_cnt and go to CHECK.
//   CHECK: sample res and compare it with |vec.
//    On a mismatch, increment err_count (saturating).
//    If first_fail_valid==0, also capture first_fail_vec=vec and set first_fail_valid.
//    If vec==4'hF, go to DONE. Otherwise increment vec and return to SETTLE.
//   DONE: done=1 for this single cycle; pass=(err_count==0) and stays registered; then go to IDLE.
//  Timing: each vector takes SETTLE_CYCLES+1 cycles. A full run takes 16*(SETTLE_CYCLES+1)
//   cycles from the first SETTLE cycle to DONE (48 cycles with defaults).
//  start asserted while busy is ignored and neither restarts nor queues a run.
//  Results (err_count, first_fail_*, pass) hold after DONE until the next accepted start.
//  {a,b,c,d} only change on the CHECK->SETTLE edge, so they are glitch-free per vector.
//   They hold their last value (4'hF) while IDLE after a run.
// CONFIGURATION
//  Macro OR4CHK_STOP_ON_FAIL_EN:
//   Defined: the first mismatch in CHECK goes straight to DONE. err_count ends at 1,
//    pass=0, and the remaining vectors are not applied.
//   Undefined (default): all 16 vectors always run and every mismatch is counted.
// STRUCTURE
//  Shared package or4chk_pkg: state enum typedef (IDLE/SETTLE/CHECK/DONE),
//   localparams VEC_W=4, LAST_VEC=4'hF.
//  One sub-module, or4_golden: a combinational 4-bit OR giving the expected result.
//   It keeps the compare path separate from the CUT.
//  Wait counter width: $clog2(SETTLE_CYCLES+1).
// TESTING
//  1. Correct or4 CUT, pulse start -> done after 48 cycles; err_count=0, pass=1, first_fail_valid=0.
//  2. CUT stuck-at-0 -> err_count=15, pass=0, first_fail_vec=4'b0001, first_fail_valid=1.
//  3. CUT stuck-at-1 -> err_count=1, first_fail_vec=4'b0000, pass=0.
//  4. start pulsed again at cycle 10 of a run -> ignored; done still arrives at cycle 48 with one pulse.
//  5. rst_n=0 at cycle 20 mid-run -> next cycle: IDLE, busy=0, err_count=0, {a,b,c,d}=0.
//     A new start then completes normally.
//  6. With OR4CHK_STOP_ON_FAIL_EN and a stuck-at-0 CUT -> done after vector 4'b0001 (cycle 6);
//     err_count=1, pass=0.

Source files
------------

// File: rtl/or4chk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : or4chk_pkg
// Brief    : Shared state encoding and vector constants for the OR4 checker.
// Revision : 1.0
// ============================================================================
package or4chk_pkg;

    localparam int              VEC_W    = 4;
    localparam logic [VEC_W-1:0] LAST_VEC = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/or4_golden.sv
`default_nettype none
// ============================================================================
// Module   : or4_golden
// Brief    : Golden 4-input OR giving the expected CUT response.
// Revision : 1.0
// ============================================================================
module or4_golden
    import or4chk_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic             expected
);

    assign expected = |vec;

endmodule
`default_nettype wire

// File: rtl/or4_vector_checker.sv
`default_nettype none
// ============================================================================
// Module   : or4_vector_checker
// Brief    : Drives all 16 vectors into an OR4 CUT and counts mismatches.
//            Option macro: OR4CHK_STOP_ON_FAIL_EN (end run on first mismatch).
// Revision : 1.0
// ============================================================================
module or4_vector_checker
    import or4chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    input  logic             res,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [VEC_W-1:0] first_fail_vec,
    output logic             first_fail_valid
);

    localparam int WAIT_W = $clog2(SETTLE_CYCLES + 1);

    state_t              state;
    state_t              state_nx;
    logic [VEC_W-1:0]    vec;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                expected;
    logic                mismatch;
    logic                settle_last;
    logic [ERR_W-1:0]    err_next;

    or4_golden u_golden (
        .vec      (vec),
        .expected (expected)
    );

    // The vector register drives the CUT directly, so its pins only move
    // when vec itself is updated on the CHECK->SETTLE edge.
    assign {a, b, c, d} = vec;
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);

    assign settle_last = (wait_cnt == WAIT_W'(SETTLE_CYCLES - 1));
    assign mismatch    = (state == CHECK) && (res != expected);
    assign err_next    = (mismatch && (err_count != {ERR_W{1'b1}}))
                         ? err_count + ERR_W'(1) : err_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SETTLE;
            SETTLE:  if (settle_last) state_nx = CHECK;
            CHECK: begin
`ifdef OR4CHK_STOP_ON_FAIL_EN
                if (mismatch || (vec == LAST_VEC)) state_nx = DONE;
                else                               state_nx = SETTLE;
`else
                if (vec == LAST_VEC) state_nx = DONE;
                else                 state_nx = SETTLE;
`endif
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec              <= '0;
            wait_cnt         <= '0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vec              <= '0;
                        wait_cnt         <= '0;
                        pass             <= 1'b0;
                        err_count        <= '0;
                        first_fail_vec   <= '0;
                        first_fail_valid <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (settle_last) wait_cnt <= '0;
                    else             wait_cnt <= wait_cnt + WAIT_W'(1);
                end
                CHECK: begin
                    err_count <= err_next;
                    if (mismatch && !first_fail_valid) begin
                        first_fail_vec   <= vec;
                        first_fail_valid <= 1'b1;
                    end
                    // pass is loaded here so it is already valid while done is high
                    if (state_nx == DONE) pass <= (err_next == '0);
                    else                  vec  <= vec + VEC_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_or4_vector_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_or4_vector_checker
// Brief    : Self-checking bench; CUT faults are modelled as a per-vector flip mask.
// Revision : 1.0
// ============================================================================
module tb_or4_vector_checker;

    localparam int SETTLE     = 2;
    localparam int PER_VEC    = SETTLE + 1;
    localparam int RUN_CYCLES = 16 * PER_VEC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       a, b, c, d, res;
    logic       busy, done, pass;
    logic [7:0] err_count;
    logic [3:0] first_fail_vec;
    logic       first_fail_valid;
    logic [15:0] fault_mask = '0;
    logic [3:0]  cur_vec;

    int checks = 0;
    int errors = 0;

    // Behavioural CUT: correct OR of the pins, inverted on every vector marked in fault_mask
    assign cur_vec = {a, b, c, d};
    assign res     = (cur_vec != 4'd0) ^ fault_mask[cur_vec];

    always #5 clk = ~clk;

    or4_vector_checker #(.SETTLE_CYCLES(SETTLE), .ERR_W(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .a                (a),
        .b                (b),
        .c                (c),
        .d                (d),
        .res              (res),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .first_fail_vec   (first_fail_vec),
        .first_fail_valid (first_fail_valid)
    );

    typedef struct {
        string       name;
        logic [15:0] mask;
        int          err;
        int          first;
        int          valid;
        int          pass;
    } vec_rec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: expected result of a full run against a given fault mask
    task automatic model(input logic [15:0] m, output int e_err, output int e_first,
                         output int e_valid, output int e_pass);
        e_err = 0; e_first = 0; e_valid = 0;
        for (int v = 0; v < 16; v++) begin
            if (m[v]) begin
                if (e_valid == 0) begin
                    e_first = v;
                    e_valid = 1;
                end
                e_err++;
            end
        end
`ifdef OR4CHK_STOP_ON_FAIL_EN
        if (e_valid != 0) e_err = 1;
`endif
        e_pass = (e_err == 0) ? 1 : 0;
    endtask

    function automatic int exp_cycles(input int valid, input int first);
`ifdef OR4CHK_STOP_ON_FAIL_EN
        return (valid != 0) ? (first + 1) * PER_VEC : RUN_CYCLES;
`else
        return RUN_CYCLES;
`endif
    endfunction

    function automatic int exp_last(input int valid, input int first);
`ifdef OR4CHK_STOP_ON_FAIL_EN
        return (valid != 0) ? first : 15;
`else
        return 15;
`endif
    endfunction

    task automatic run(input string nm, input logic [15:0] m, input int e_err, input int e_first,
                       input int e_valid, input int e_pass, input int restart_at);
        int  cnt, done_at, n_done;
        bit  seq_ok, busy_ok;
        fault_mask = m;
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        cnt     = 0;
        done_at = -1;
        n_done  = 0;
        seq_ok  = (cur_vec === 4'd0);
        busy_ok = (busy === 1'b1);
        while (done_at < 0 && cnt < 4 * RUN_CYCLES) begin
            start = (cnt == restart_at);
            @(posedge clk); #1;
            start = 1'b0;
            cnt++;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) done_at = cnt;
            else if (cur_vec !== 4'(cnt / PER_VEC)) seq_ok = 1'b0;
        end
        check({nm, "/done_cycle"}, done_at, exp_cycles(e_valid, e_first));
        check({nm, "/vec_seq"}, 32'(seq_ok), 1);
        check({nm, "/busy_run"}, 32'(busy_ok), 1);
        check({nm, "/err_count"}, 32'(err_count), e_err);
        check({nm, "/first_vec"}, 32'(first_fail_vec), e_first);
        check({nm, "/first_valid"}, 32'(first_fail_valid), e_valid);
        check({nm, "/pass"}, 32'(pass), e_pass);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) n_done++;
        end
        check({nm, "/done_pulse"}, n_done, 0);
        check({nm, "/busy_idle"}, 32'(busy), 0);
        check({nm, "/hold_err"}, 32'(err_count), e_err);
        check({nm, "/hold_pass"}, 32'(pass), e_pass);
        check({nm, "/hold_vec"}, 32'(cur_vec), exp_last(e_valid, e_first));
    endtask

    vec_rec_t tbl[5];

    initial begin
        int e_err, e_first, e_valid, e_pass;
        logic [15:0] m;

        tbl[0] = '{"correct",   16'h0000,  0,  0, 0, 1};
        tbl[1] = '{"stuck0",    16'hFFFE, 15,  1, 1, 0};
        tbl[2] = '{"stuck1",    16'h0001,  1,  0, 1, 0};
        tbl[3] = '{"last_only", 16'h8000,  1, 15, 1, 0};
        tbl[4] = '{"two_bad",   16'h0240,  2,  6, 1, 0};

        repeat (3) @(posedge clk);
        #1;
        check("reset/busy", 32'(busy), 0);
        check("reset/done", 32'(done), 0);
        check("reset/pass", 32'(pass), 0);
        check("reset/err", 32'(err_count), 0);
        check("reset/vec", 32'(cur_vec), 0);
        check("reset/ff", 32'({first_fail_vec, first_fail_valid}), 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_start/busy", 32'(busy), 0);

        foreach (tbl[i]) begin
            e_err = tbl[i].err;
`ifdef OR4CHK_STOP_ON_FAIL_EN
            if (tbl[i].valid != 0) e_err = 1;
`endif
            run(tbl[i].name, tbl[i].mask, e_err, tbl[i].first, tbl[i].valid, tbl[i].pass, -1);
        end

        // start while busy must not restart the vector walk
        run("restart_ignored", 16'h0000, 0, 0, 0, 1, 9);

        // reset mid-run with errors already accumulated
        fault_mask = 16'hFFFE;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset/busy", 32'(busy), 0);
        check("midreset/done", 32'(done), 0);
        check("midreset/err", 32'(err_count), 0);
        check("midreset/vec", 32'(cur_vec), 0);
        check("midreset/ff_valid", 32'(first_fail_valid), 0);
        check("midreset/pass", 32'(pass), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run("after_reset", 16'h0000, 0, 0, 0, 1, -1);

        for (int k = 0; k < 8; k++) begin
            m = 16'($urandom) & 16'($urandom);
            if (k == 3) m = 16'h0000;
            model(m, e_err, e_first, e_valid, e_pass);
            run($sformatf("rand%0d_%04h", k, m), m, e_err, e_first, e_valid, e_pass, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
